branch_unit_seq: RTL and testbench
==================================

Name: branch_unit_seq

Overview:
Parametrised, multi-cycle successor to the single-shot branch unit. It resolves one RISC-V control-transfer instruction per start/done handshake: BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL and JALR.
- Sequences register-file reads and one target-address add over the shared register and ALU buses.
- Generates the redirect PC and the JAL/JALR link write-back.
- Flags illegal instructions and misaligned targets.
- Keeps a saturating taken-branch counter.

Parameters:
XLEN, 32, datapath and PC width
REG_SELECT_LEN, 5, register-select width
COUNT_WIDTH, 16, taken-counter width
ALU_OP_ADD, 3'b000, alu_op code driven for the target add

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable_n  in  1  active-low; when high, start is ignored
start  in  1  request; sampled only while ready=1
ready  out  1  high when the unit is idle
done  out  1  one-cycle pulse; result outputs are valid
instruction  in  32  instruction, latched on start
program_counter  in  XLEN  PC of the instruction, latched on start
register_1  out  REG_SELECT_LEN  rs1 select; z outside READ
register_2  out  REG_SELECT_LEN  rs2 select; z outside READ
register_data_1  in  XLEN  rs1 value
register_data_2  in  XLEN  rs2 value
alu_a  out  XLEN  ALU operand A; z outside EXEC
alu_b  out  XLEN  ALU operand B; z outside EXEC
alu_op  out  3  ALU operation; z outside EXEC
alu_out  in  XLEN  ALU result, combinational from alu_a/alu_b
load_new_pc  out  1  redirect request, valid with done
new_pc  out  XLEN  redirect target
rd_write  out  1  link write strobe, valid with done
rd_select  out  REG_SELECT_LEN  link destination register
rd_data  out  XLEN  link value (PC+4)
illegal  out  1  unsupported instruction, valid with done
misaligned  out  1  target[1:0] != 0, valid with done
count_clear  in  1  synchronous clear of taken_count
taken_count  out  COUNT_WIDTH  saturating count of redirects

Behaviour:
- Reset values:
  - state = IDLE, so ready = 1.
  - done, load_new_pc, rd_write, illegal, misaligned = 0.
  - new_pc, rd_select, rd_data, taken_count = 0.
  - Bus outputs (register_*, alu_*) = z.
- Reset asserted mid-operation aborts the operation; on the next edge all of the above hold and no done pulse is issued.
- FSM: IDLE -> READ -> EXEC -> DONE -> IDLE.
  - IDLE: start=1 with enable_n=0 latches instruction and program_counter and moves to READ.
  - Latency is fixed for every instruction: done is high in the 3rd cycle after the start edge.
  - ready = (state == IDLE). start outside IDLE is ignored. Back-to-back starts are accepted every 4 cycles.
- enable_n only gates acceptance; an in-flight operation always completes.
- READ:
  - Drives register_1 = inst[19:15] and register_2 = inst[24:20].
  - Captures register_data_1/2 at the end of the cycle.
  - JAL also passes through READ; the captured data is unused.
- EXEC:
  - Branch: alu_a = PC, alu_b = B-immediate.
  - JAL: alu_a = PC, alu_b = J-immediate.
  - JALR: alu_a = rs1 data, alu_b = I-immediate.
  - alu_op = ALU_OP_ADD in all cases.
  - Comparison is internal: EQ, NE, signed LT/GE, unsigned LTU/GEU on the captured operands.
  - Target = alu_out sampled at the end of EXEC. For JALR, bit 0 of the target is cleared.
- Immediates (sign-extended to XLEN):
  - B = {i[31], i[7], i[30:25], i[11:8], 0}.
  - J = {i[31], i[19:12], i[20], i[30:21], 0}.
  - I = i[31:20].
- Decode:
  - Opcodes: 1100011 branch, 1101111 JAL, 1100111 JALR.
  - Branch funct3 010/011 is illegal. JALR funct3 != 000 is illegal. Any other opcode is illegal.
- DONE (registered outputs, held until the next DONE or reset):
  - taken = jump, or branch condition true.
  - misaligned = taken & target[1:0] != 0.
  - load_new_pc = taken & !misaligned & !illegal.
  - new_pc = target when load_new_pc, else PC+4.
  - rd_write = jump & !illegal & !misaligned & rd != 0.
  - rd_select = inst[11:7].
  - rd_data = PC+4, wrapping modulo 2^XLEN.
  - illegal forces load_new_pc = 0 and rd_write = 0.
- Strobes: load_new_pc, rd_write and done are valid only while done=1. done is deasserted in every other state.
- taken_count:
  - +1 on each DONE cycle with load_new_pc = 1, saturating at all-ones.
  - count_clear has priority over a simultaneous increment; the result is 0.

Test Plan:
- BEQ: inst 0x00208463 (rs1=1, rs2=2, +8), PC 0x100, both operands 5, bench ALU adds -> done at cycle 3, load_new_pc=1, new_pc=0x108, rd_write=0, taken_count=1.
- Signedness: BLT vs BLTU, rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken (new_pc=PC+4, load_new_pc=0).
- JALR: inst 0x005280E7 (rd=1, rs1=5, imm 5), rs1 data 0x1000, PC 0x200 -> new_pc=0x1004, rd_write=1, rd_select=1, rd_data=0x204.
- Misaligned BEQ: inst 0x00208363 (+6), PC 0x100, equal operands -> misaligned=1, load_new_pc=0, taken_count unchanged.
- Illegal branch funct3 010 -> illegal=1, load_new_pc=0, rd_write=0. With COUNT_WIDTH=2 and 5 taken branches -> taken_count=3. Same-cycle count_clear and increment -> taken_count=0.
- Reset asserted in EXEC -> next cycle ready=1, bus outputs z, no done pulse. start with enable_n=1 -> ready stays 1.

Source files
------------

// File: rtl/branch_unit_seq.sv
// Multi-cycle RISC-V branch/jump resolver: reads operands, adds the target on the
// shared ALU, then presents redirect, link write-back and fault flags for one cycle.
module branch_unit_seq #(
  parameter int          XLEN           = 32,
  parameter int          REG_SELECT_LEN = 5,
  parameter int          COUNT_WIDTH    = 16,
  parameter logic [2:0]  ALU_OP_ADD     = 3'b000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_n,
  input  logic                      start,
  output logic                      ready,
  output logic                      done,
  input  logic [31:0]               instruction,
  input  logic [XLEN-1:0]           program_counter,
  output logic [REG_SELECT_LEN-1:0] register_1,
  output logic [REG_SELECT_LEN-1:0] register_2,
  input  logic [XLEN-1:0]           register_data_1,
  input  logic [XLEN-1:0]           register_data_2,
  output logic [XLEN-1:0]           alu_a,
  output logic [XLEN-1:0]           alu_b,
  output logic [2:0]                alu_op,
  input  logic [XLEN-1:0]           alu_out,
  output logic                      load_new_pc,
  output logic [XLEN-1:0]           new_pc,
  output logic                      rd_write,
  output logic [REG_SELECT_LEN-1:0] rd_select,
  output logic [XLEN-1:0]           rd_data,
  output logic                      illegal,
  output logic                      misaligned,
  input  logic                      count_clear,
  output logic [COUNT_WIDTH-1:0]    taken_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Handshake: start is accepted only on a cycle where ready=1 and enable_n=0;
  // done then pulses exactly three cycles later, and the strobes are valid only with it.

  state_t                    state_q, state_d;
  logic [31:0]               inst_q, inst_d;
  logic [XLEN-1:0]           pc_q, pc_d;
  logic [XLEN-1:0]           rs1_q, rs1_d;
  logic [XLEN-1:0]           rs2_q, rs2_d;
  logic                      load_q, load_d;
  logic [XLEN-1:0]           new_pc_q, new_pc_d;
  logic                      rd_write_q, rd_write_d;
  logic [REG_SELECT_LEN-1:0] rd_select_q, rd_select_d;
  logic [XLEN-1:0]           rd_data_q, rd_data_d;
  logic                      illegal_q, illegal_d;
  logic                      mis_q, mis_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_branch, is_jal, is_jalr, branch_ok, jump, cond, taken;
  logic            illegal_c, mis_c, load_c;
  logic [XLEN-1:0] imm_b, imm_j, imm_i, alu_a_c, alu_b_c, target_c, pc_plus4;

  assign opcode    = inst_q[6:0];
  assign funct3    = inst_q[14:12];
  assign is_branch = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign branch_ok = is_branch && (funct3 != 3'b010) && (funct3 != 3'b011);
  assign jump      = is_jal || is_jalr;
  assign illegal_c = !(branch_ok || is_jal || (is_jalr && (funct3 == 3'b000)));

  assign imm_b = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};

  assign alu_a_c  = is_jalr ? rs1_q : pc_q;
  assign alu_b_c  = is_jalr ? imm_i : (is_jal ? imm_j : imm_b);
  assign target_c = is_jalr ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign taken  = jump || (branch_ok && cond);
  assign mis_c  = taken && (target_c[1:0] != 2'b00);
  assign load_c = taken && !mis_c && !illegal_c;

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    load_d      = load_q;
    new_pc_d    = new_pc_q;
    rd_write_d  = rd_write_q;
    rd_select_d = rd_select_q;
    rd_data_d   = rd_data_q;
    illegal_d   = illegal_q;
    mis_d       = mis_q;
    case (state_q)
      S_IDLE: begin
        if (start && !enable_n) begin
          inst_d  = instruction;
          pc_d    = program_counter;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rs1_d   = register_data_1;
        rs2_d   = register_data_2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        load_d      = load_c;
        new_pc_d    = load_c ? target_c : pc_plus4;
        rd_write_d  = jump && !illegal_c && !mis_c && (inst_q[11:7] != 5'd0);
        rd_select_d = REG_SELECT_LEN'(inst_q[11:7]);
        rd_data_d   = pc_plus4;
        illegal_d   = illegal_c;
        mis_d       = mis_c;
        state_d     = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Clear wins over an increment landing on the same edge.
  always_comb begin
    count_d = count_q;
    if (count_clear)
      count_d = '0;
    else if ((state_q == S_DONE) && load_q && (count_q != {COUNT_WIDTH{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      load_q      <= 1'b0;
      new_pc_q    <= '0;
      rd_write_q  <= 1'b0;
      rd_select_q <= '0;
      rd_data_q   <= '0;
      illegal_q   <= 1'b0;
      mis_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      load_q      <= load_d;
      new_pc_q    <= new_pc_d;
      rd_write_q  <= rd_write_d;
      rd_select_q <= rd_select_d;
      rd_data_q   <= rd_data_d;
      illegal_q   <= illegal_d;
      mis_q       <= mis_d;
      count_q     <= count_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign load_new_pc = load_q && done;
  assign rd_write    = rd_write_q && done;
  assign new_pc      = new_pc_q;
  assign rd_select   = rd_select_q;
  assign rd_data     = rd_data_q;
  assign illegal     = illegal_q;
  assign misaligned  = mis_q;
  assign taken_count = count_q;

  // Shared buses are released whenever this unit is not the owner.
  assign register_1 = (state_q == S_READ) ? REG_SELECT_LEN'(inst_q[19:15]) : {REG_SELECT_LEN{1'bz}};
  assign register_2 = (state_q == S_READ) ? REG_SELECT_LEN'(inst_q[24:20]) : {REG_SELECT_LEN{1'bz}};
  assign alu_a      = (state_q == S_EXEC) ? alu_a_c    : {XLEN{1'bz}};
  assign alu_b      = (state_q == S_EXEC) ? alu_b_c    : {XLEN{1'bz}};
  assign alu_op     = (state_q == S_EXEC) ? ALU_OP_ADD : 3'bzzz;

endmodule

// File: tb/tb_branch_unit_seq.sv
// Bench for branch_unit_seq: directed cases plus random instructions, scored against
// a spec-level model; a second instance with a 2-bit counter covers saturation.
module tb_branch_unit_seq;

  localparam int W = 123;

  logic        clk = 1'b0;
  logic        reset, enable_n, start, count_clear;
  logic [31:0] instruction, program_counter;
  logic [31:0] register_data_1, register_data_2, alu_out;
  wire  [4:0]  register_1, register_2;
  wire  [31:0] alu_a, alu_b;
  wire  [2:0]  alu_op;
  logic        ready, done, load_new_pc, rd_write, illegal, misaligned;
  logic [31:0] new_pc, rd_data;
  logic [4:0]  rd_select;
  logic [15:0] taken_count;

  logic [31:0] rd1_b, rd2_b, alu_out_b;
  wire  [4:0]  reg1_b, reg2_b;
  wire  [31:0] alu_a_b, alu_b_b;
  wire  [2:0]  alu_op_b;
  logic        ready_b, done_b, load_b, rdw_b, ill_b, mis_b;
  logic [31:0] npc_b, rdd_b;
  logic [4:0]  rds_b;
  logic [1:0]  taken_count_b;

  logic [31:0] regfile [32];
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_cnt = 0;
  int model_cnt_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign register_data_1 = regfile[register_1];
  assign register_data_2 = regfile[register_2];
  assign alu_out         = alu_a + alu_b;
  assign rd1_b           = regfile[reg1_b];
  assign rd2_b           = regfile[reg2_b];
  assign alu_out_b       = alu_a_b + alu_b_b;

  branch_unit_seq dut (
    .clk(clk), .reset(reset), .enable_n(enable_n), .start(start), .ready(ready), .done(done),
    .instruction(instruction), .program_counter(program_counter),
    .register_1(register_1), .register_2(register_2),
    .register_data_1(register_data_1), .register_data_2(register_data_2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .load_new_pc(load_new_pc), .new_pc(new_pc), .rd_write(rd_write), .rd_select(rd_select),
    .rd_data(rd_data), .illegal(illegal), .misaligned(misaligned),
    .count_clear(count_clear), .taken_count(taken_count)
  );

  branch_unit_seq #(.COUNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .enable_n(enable_n), .start(start), .ready(ready_b), .done(done_b),
    .instruction(instruction), .program_counter(program_counter),
    .register_1(reg1_b), .register_2(reg2_b),
    .register_data_1(rd1_b), .register_data_2(rd2_b),
    .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_op(alu_op_b), .alu_out(alu_out_b),
    .load_new_pc(load_b), .new_pc(npc_b), .rd_write(rdw_b), .rd_select(rds_b),
    .rd_data(rdd_b), .illegal(ill_b), .misaligned(mis_b),
    .count_clear(count_clear), .taken_count(taken_count_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain reading of the RISC-V rules, operands as numbers.
  task automatic model(input logic [31:0] inst, pc, a, b,
                       output logic ld, output logic [31:0] npc, output logic rdw,
                       output logic ill, output logic mis,
                       output logic [31:0] ea, output logic [31:0] eb, output logic known);
    logic [31:0] ib, ij, ii, target;
    logic t, jmp;
    ib = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    ij = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    ii = {{20{inst[31]}}, inst[31:20]};
    t = 0; jmp = 0; ill = 0; target = 0; known = 1; ea = pc; eb = ib;
    case (inst[6:0])
      7'b1100011: begin
        target = pc + ib;
        case (inst[14:12])
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a < b);
          3'd7: t = (a >= b);
          default: ill = 1;
        endcase
      end
      7'b1101111: begin target = pc + ij; t = 1; jmp = 1; eb = ij; end
      7'b1100111: begin
        target = (a + ii) & ~32'd1; t = 1; jmp = 1; ill = (inst[14:12] != 0); ea = a; eb = ii;
      end
      default: begin ill = 1; known = 0; end
    endcase
    mis = t && (target[1:0] != 0);
    ld  = t && !mis && !ill;
    npc = ld ? target : pc + 32'd4;
    rdw = jmp && !ill && !mis && (inst[11:7] != 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    if (!ready) chk("ready_timeout", {63'd0, ready}, 64'd1);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    logic ld, rdw, ill, mis, known;
    logic [31:0] npc, ea, eb, a, b;
    wait_ready();
    a = regfile[inst[19:15]];
    b = regfile[inst[24:20]];
    model(inst, pc, a, b, ld, npc, rdw, ill, mis, ea, eb, known);
    exp_q.push_back({cyc + 32'd3, model_cnt_b[1:0], model_cnt[15:0], mis, ill,
                     pc + 32'd4, inst[11:7], rdw, npc, ld});
    if (ld) begin
      if (model_cnt < 16'hFFFF) model_cnt++;
      if (model_cnt_b < 3) model_cnt_b++;
    end
    instruction = inst; program_counter = pc; enable_n = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("read_rs1_sel", {59'd0, register_1}, {59'd0, inst[19:15]});
    chk("read_rs2_sel", {59'd0, register_2}, {59'd0, inst[24:20]});
    @(negedge clk);
    if (known) begin
      chk("exec_alu_a", {32'd0, alu_a}, {32'd0, ea});
      chk("exec_alu_b", {32'd0, alu_b}, {32'd0, eb});
      chk("exec_alu_op", {61'd0, alu_op}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("done_cycle",    64'(cyc),          {32'd0, e[122:91]});
        chk("taken_count_b", 64'(taken_count_b), {62'd0, e[90:89]});
        chk("taken_count",   64'(taken_count),   {48'd0, e[88:73]});
        chk("misaligned",    64'(misaligned),    {63'd0, e[72]});
        chk("illegal",       64'(illegal),       {63'd0, e[71]});
        chk("rd_data",       64'(rd_data),       {32'd0, e[70:39]});
        chk("rd_select",     64'(rd_select),     {59'd0, e[38:34]});
        chk("rd_write",      64'(rd_write),      {63'd0, e[33]});
        chk("new_pc",        64'(new_pc),        {32'd0, e[32:1]});
        chk("load_new_pc",   64'(load_new_pc),   {63'd0, e[0]});
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !ready) && n < 50) begin @(negedge clk); n++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    int sel;
    i = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 5) i[6:0] = 7'b1100011;
    else if (sel == 6) i[6:0] = 7'b1101111;
    else if (sel <= 8) begin
      i[6:0] = 7'b1100111;
      if ($urandom_range(0, 3) != 0) i[14:12] = 3'b000;
    end else begin
      while (i[6:0] == 7'b1100011 || i[6:0] == 7'b1101111 || i[6:0] == 7'b1100111)
        i[6:0] = 7'($urandom);
    end
    return i;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'd0;
    reset = 1'b1; enable_n = 1'b0; start = 1'b0; count_clear = 1'b0;
    instruction = 32'd0; program_counter = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_new_pc", 64'(new_pc), 64'd0);
    chk("rst_taken_count", 64'(taken_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    regfile[1] = 32'd5; regfile[2] = 32'd5;
    issue(32'h00208463, 32'h100);
    regfile[1] = 32'hFFFFFFFF; regfile[2] = 32'd1;
    issue(32'h0020C463, 32'h300);
    issue(32'h0020E463, 32'h300);
    regfile[5] = 32'h1000;
    issue(32'h005280E7, 32'h200);
    regfile[1] = 32'd7; regfile[2] = 32'd7;
    issue(32'h00208363, 32'h100);
    issue(32'h0020A463, 32'h100);
    drain();

    // Clear coinciding with the increment of a taken branch.
    issue(32'h00208463, 32'h100);
    begin
      int n = 0;
      while (!done && n < 10) begin @(negedge clk); n++; end
    end
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    model_cnt = 0; model_cnt_b = 0;
    chk("clear_wins", 64'(taken_count), 64'd0);
    chk("clear_wins_b", 64'(taken_count_b), 64'd0);

    repeat (5) issue(32'h00208463, 32'h100);
    drain();
    chk("sat_count_b", 64'(taken_count_b), 64'd3);
    chk("count_five", 64'(taken_count), 64'd5);

    // Reset while the unit is in EXEC: no done, everything back to idle values.
    wait_ready();
    instruction = 32'h008000EF; program_counter = 32'h40; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_cnt = 0; model_cnt_b = 0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rd_data", 64'(rd_data), 64'd0);
    chk("abort_count", 64'(taken_count), 64'd0);
    repeat (4) @(negedge clk);

    enable_n = 1'b1; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("enable_n_blocks", 64'(ready), 64'd1);
    end
    start = 1'b0; enable_n = 1'b0;

    for (int k = 0; k < 200; k++) begin
      logic [31:0] inst;
      inst = rand_inst();
      case ($urandom_range(0, 2))
        0: begin regfile[inst[19:15]] = $urandom; regfile[inst[24:20]] = regfile[inst[19:15]]; end
        1: begin regfile[inst[19:15]] = $urandom_range(0, 8); regfile[inst[24:20]] = $urandom_range(0, 8); end
        default: begin regfile[inst[19:15]] = $urandom; regfile[inst[24:20]] = $urandom; end
      endcase
      issue(inst, $urandom & 32'hFFFFFFFC);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
